// File: rtl/fan_pkg.sv
// rtl/fan_pkg.sv - shared encodings and preset helpers for the fan controller
//
// Purpose: fan mode and timer-select encodings, timer preset unit counts and
//          small helpers used by the controller top.
// Ports:   none (package).
package fan_pkg;

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_LOW  = 2'd1,
    ST_MID  = 2'd2,
    ST_HIGH = 2'd3
  } fan_state_e;

  typedef enum logic [1:0] {
    TSEL_NONE = 2'd0,
    TSEL_T1   = 2'd1,
    TSEL_T3   = 2'd2,
    TSEL_T5   = 2'd3
  } timer_sel_e;

  localparam int unsigned PRESET_T1_UNITS = 1;
  localparam int unsigned PRESET_T3_UNITS = 3;
  localparam int unsigned PRESET_T5_UNITS = 5;

  // Timer preset cycle: NONE -> T1 -> T3 -> T5 -> NONE.
  function automatic timer_sel_e next_timer_sel(input timer_sel_e sel);
    case (sel)
      TSEL_NONE: next_timer_sel = TSEL_T1;
      TSEL_T1:   next_timer_sel = TSEL_T3;
      TSEL_T3:   next_timer_sel = TSEL_T5;
      default:   next_timer_sel = TSEL_NONE;
    endcase
  endfunction

  function automatic int unsigned preset_units(input timer_sel_e sel);
    case (sel)
      TSEL_T1: preset_units = PRESET_T1_UNITS;
      TSEL_T3: preset_units = PRESET_T3_UNITS;
      TSEL_T5: preset_units = PRESET_T5_UNITS;
      default: preset_units = 0;
    endcase
  endfunction

endpackage

// File: rtl/fan_speed_controller_if.sv
// rtl/fan_speed_controller_if.sv - button pulses and fan status/motor outputs
//
// Purpose: groups the button front-end pulses and the controller outputs.
// Signals:
//   i_btn_speed, i_btn_off, i_btn_timer : one-cycle button pulses (to controller)
//   o_pwm          : motor PWM
//   o_state        : 0=OFF 1=LOW 2=MID 3=HIGH
//   o_timer_sel    : 0=NONE 1=T1 2=T3 3=T5
//   o_timer_remain : whole timer units left, 0 when idle
//   o_led          : one-hot of o_state
// Modports: master drives the buttons, slave is the controller.
interface fan_speed_controller_if #(
  parameter int unsigned TIMER_W = 16
);

  logic               i_btn_speed;
  logic               i_btn_off;
  logic               i_btn_timer;
  logic               o_pwm;
  logic [1:0]         o_state;
  logic [1:0]         o_timer_sel;
  logic [TIMER_W-1:0] o_timer_remain;
  logic [3:0]         o_led;

  modport master (
    output i_btn_speed, i_btn_off, i_btn_timer,
    input  o_pwm, o_state, o_timer_sel, o_timer_remain, o_led
  );

  modport slave (
    input  i_btn_speed, i_btn_off, i_btn_timer,
    output o_pwm, o_state, o_timer_sel, o_timer_remain, o_led
  );

endinterface

// File: rtl/fan_pwm_gen.sv
// rtl/fan_pwm_gen.sv - free-running PWM with duty latched at period start
//
// Purpose: period counter 0..PWM_PERIOD-1, duty register that only loads on
//          counter wrap (so a period is never truncated or stretched), and a
//          registered compare output.
// Ports:
//   i_clk   : clock
//   i_reset : asynchronous active-high reset
//   i_duty  : requested high clocks per period (< PWM_PERIOD)
//   o_pwm   : registered PWM output
module fan_pwm_gen #(
  parameter int unsigned PWM_PERIOD = 1000,
  localparam int unsigned CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [CNT_W-1:0] i_duty,
  output logic             o_pwm
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             pwm_q, pwm_d;
  logic             wrap;

  assign wrap = (cnt_q == CNT_W'(PWM_PERIOD - 1));

  always_comb begin
    cnt_d  = wrap ? '0 : cnt_q + CNT_W'(1);
    duty_d = wrap ? i_duty : duty_q;
    // Compare against next-cycle values so o_pwm lines up with the counter.
    pwm_d  = (cnt_d < duty_d);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign o_pwm = pwm_q;

endmodule

// File: rtl/fan_speed_controller.sv
// rtl/fan_speed_controller.sv - fan mode FSM, auto-off timer and PWM drive
//
// Purpose: consumes button pulses (priority off > speed > timer), runs the
//          OFF/LOW/MID/HIGH mode FSM and the optional auto-off countdown,
//          and drives the motor PWM and LED status.
// Build option: FAN_TIMER_EN builds the countdown timer; without it the timer
//          button is ignored and the timer outputs read 0.
// Ports:
//   i_clk   : clock
//   i_reset : asynchronous active-high reset
//   bus     : fan_speed_controller_if.slave (buttons in, pwm/state/timer/led out)
module fan_speed_controller
  import fan_pkg::*;
#(
  parameter int unsigned PWM_PERIOD  = 1000,
  parameter int unsigned DUTY_LOW    = 300,
  parameter int unsigned DUTY_MID    = 600,
  parameter int unsigned DUTY_HIGH   = 900,
  parameter int unsigned UNIT_CYCLES = 100_000_000,
  parameter int unsigned TIMER_W     = 16
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  fan_speed_controller_if.slave  bus
);

  localparam int unsigned CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

  fan_state_e       state_q, state_d;
  logic             act_off;
  logic             act_speed;
  logic [CNT_W-1:0] duty;

  // Only the highest-priority pulse acts; lower ones are dropped.
  assign act_off   = bus.i_btn_off;
  assign act_speed = bus.i_btn_speed & ~bus.i_btn_off;

`ifdef FAN_TIMER_EN
  localparam int unsigned PRE_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

  timer_sel_e         sel_q, sel_d;
  timer_sel_e         sel_nx;
  logic [TIMER_W-1:0] remain_q, remain_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic               act_timer;

  assign act_timer = bus.i_btn_timer & ~bus.i_btn_off & ~bus.i_btn_speed;
  assign sel_nx    = next_timer_sel(sel_q);
`endif

  always_comb begin
    state_d = state_q;
    if (act_off) begin
      state_d = ST_OFF;
    end else if (act_speed) begin
      // Speed never wraps back to OFF.
      case (state_q)
        ST_OFF:  state_d = ST_LOW;
        ST_LOW:  state_d = ST_MID;
        ST_MID:  state_d = ST_HIGH;
        default: state_d = ST_LOW;
      endcase
    end

`ifdef FAN_TIMER_EN
    sel_d    = sel_q;
    remain_d = remain_q;
    pre_d    = pre_q;
    if (act_off) begin
      sel_d    = TSEL_NONE;
      remain_d = '0;
      pre_d    = '0;
    end else if (act_timer && (state_q != ST_OFF)) begin
      // A reload wins over an expiry landing on the same edge.
      sel_d    = sel_nx;
      remain_d = TIMER_W'(preset_units(sel_nx));
      pre_d    = (sel_nx == TSEL_NONE) ? '0 : PRE_W'(UNIT_CYCLES - 1);
    end else if (remain_q != '0) begin
      if (pre_q == '0) begin
        pre_d    = PRE_W'(UNIT_CYCLES - 1);
        remain_d = remain_q - TIMER_W'(1);
        if (remain_q == TIMER_W'(1)) begin
          // Expiry overrides any speed step taken this cycle.
          state_d = ST_OFF;
          sel_d   = TSEL_NONE;
        end
      end else begin
        pre_d = pre_q - PRE_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_OFF;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef FAN_TIMER_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sel_q    <= TSEL_NONE;
      remain_q <= '0;
      pre_q    <= '0;
    end else begin
      sel_q    <= sel_d;
      remain_q <= remain_d;
      pre_q    <= pre_d;
    end
  end

  assign bus.o_timer_sel    = sel_q;
  assign bus.o_timer_remain = remain_q;
`else
  logic unused_timer_btn;
  assign unused_timer_btn   = bus.i_btn_timer;
  assign bus.o_timer_sel    = 2'd0;
  assign bus.o_timer_remain = '0;
`endif

  always_comb begin
    duty = '0;
    case (state_q)
      ST_LOW:  duty = CNT_W'(DUTY_LOW);
      ST_MID:  duty = CNT_W'(DUTY_MID);
      ST_HIGH: duty = CNT_W'(DUTY_HIGH);
      default: duty = '0;
    endcase
  end

  fan_pwm_gen #(
    .PWM_PERIOD (PWM_PERIOD)
  ) u_pwm (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_duty  (duty),
    .o_pwm   (bus.o_pwm)
  );

  assign bus.o_state = state_q;
  assign bus.o_led   = 4'b0001 << state_q;

endmodule

// File: tb/tb_fan_speed_controller.sv
// tb/tb_fan_speed_controller.sv - directed self-checking bench for fan_speed_controller
module tb_fan_speed_controller;

  localparam bit TEN =
`ifdef FAN_TIMER_EN
    1'b1;
`else
    1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cyc;

  fan_speed_controller_if #(.TIMER_W(16)) bus ();

  fan_speed_controller #(
    .PWM_PERIOD  (10),
    .DUTY_LOW    (3),
    .DUTY_MID    (6),
    .DUTY_HIGH   (9),
    .UNIT_CYCLES (20),
    .TIMER_W     (16)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // cyc mirrors the PWM counter phase: counter == cyc % 10 after each tick.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_phase(input int p);
    do tick(); while ((cyc % 10) != p);
  endtask

  task automatic pulse(input logic s, input logic o, input logic t);
    bus.i_btn_speed = s;
    bus.i_btn_off   = o;
    bus.i_btn_timer = t;
    tick();
    bus.i_btn_speed = 1'b0;
    bus.i_btn_off   = 1'b0;
    bus.i_btn_timer = 1'b0;
  endtask

  task automatic expect_outs(input string tag, input int st, input int sel, input int rem);
    check({tag, "_state"}, 32'(bus.o_state), st);
    check({tag, "_led"}, 32'(bus.o_led), 32'(1) << st);
    check({tag, "_sel"}, 32'(bus.o_timer_sel), sel);
    check({tag, "_remain"}, 32'(bus.o_timer_remain), rem);
  endtask

  initial begin
    int highs;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.i_btn_speed = 1'b0;
    bus.i_btn_off   = 1'b0;
    bus.i_btn_timer = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_outs("reset", 0, 0, 0);
    check("reset_pwm", 32'(bus.o_pwm), 0);
    rst = 1'b0;
    cyc = 0;

    // Speed stepping from reset: 1,2,3,1 then MID.
    pulse(1, 0, 0); expect_outs("spd1", 1, 0, 0);
    pulse(1, 0, 0); expect_outs("spd2", 2, 0, 0);
    pulse(1, 0, 0); expect_outs("spd3", 3, 0, 0);
    pulse(1, 0, 0); expect_outs("spd4", 1, 0, 0);
    pulse(1, 0, 0); expect_outs("spd5", 2, 0, 0);
    wait_phase(9);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mid_pwm", 32'(bus.o_pwm), ((cyc % 10) < 6) ? 1 : 0);
      highs += int'(bus.o_pwm);
    end
    check("mid_highs", highs, 6);

    // Duty alignment: LOW applied, speed at count 5, new duty next period.
    pulse(1, 0, 0); pulse(1, 0, 0);
    expect_outs("to_low", 1, 0, 0);
    wait_phase(0);
    wait_phase(9);
    for (int i = 0; i < 20; i++) begin
      bus.i_btn_speed = (i == 5);
      tick();
      bus.i_btn_speed = 1'b0;
      check("align_pwm", 32'(bus.o_pwm), ((i % 10) < ((i < 10) ? 3 : 6)) ? 1 : 0);
      if (i == 5) check("align_state", 32'(bus.o_state), 2);
    end

    // Timer expiry: T1 in LOW, off exactly 20 clocks later.
    pulse(1, 0, 0); pulse(1, 0, 0);
    pulse(0, 0, 1);
    expect_outs("t1_load", 1, TEN ? 1 : 0, TEN ? 1 : 0);
    repeat (19) tick();
    expect_outs("t1_before", 1, TEN ? 1 : 0, TEN ? 1 : 0);
    tick();
    expect_outs("t1_expire", TEN ? 0 : 1, 0, 0);
    wait_phase(9);
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      highs += int'(bus.o_pwm);
    end
    check("expired_pwm_highs", highs, TEN ? 0 : 3);

    // Timer pulse on the expiry edge reloads and keeps the state.
    pulse(0, 1, 0); expect_outs("clr", 0, 0, 0);
    pulse(1, 0, 0); expect_outs("relow", 1, 0, 0);
    pulse(0, 0, 1);
    repeat (19) tick();
    pulse(0, 0, 1);
    expect_outs("expiry_reload", 1, TEN ? 2 : 0, TEN ? 3 : 0);
    pulse(0, 1, 0); expect_outs("clr2", 0, 0, 0);

    // Timer cycling; ignored in OFF.
    pulse(0, 0, 1); expect_outs("tmr_off", 0, 0, 0);
    pulse(1, 0, 0); pulse(1, 0, 0); pulse(1, 0, 0);
    expect_outs("high", 3, 0, 0);
    pulse(0, 0, 1); expect_outs("cyc_t1", 3, TEN ? 1 : 0, TEN ? 1 : 0);
    pulse(0, 0, 1); expect_outs("cyc_t3", 3, TEN ? 2 : 0, TEN ? 3 : 0);
    pulse(0, 0, 1); expect_outs("cyc_t5", 3, TEN ? 3 : 0, TEN ? 5 : 0);
    pulse(0, 0, 1); expect_outs("cyc_none", 3, 0, 0);

    // Priority.
    pulse(1, 0, 0); pulse(1, 0, 0);
    pulse(0, 0, 1); pulse(0, 0, 1);
    expect_outs("mid_t3", 2, TEN ? 2 : 0, TEN ? 3 : 0);
    pulse(1, 1, 1); expect_outs("prio_off", 0, 0, 0);
    pulse(1, 0, 1); expect_outs("prio_speed", 1, 0, 0);

    // Reset mid-run in HIGH/T5 at PWM count 4.
    pulse(1, 0, 0); pulse(1, 0, 0);
    pulse(0, 0, 1); pulse(0, 0, 1); pulse(0, 0, 1);
    expect_outs("high_t5", 3, TEN ? 3 : 0, TEN ? 5 : 0);
    wait_phase(0);
    wait_phase(4);
    check("pre_rst_pwm", 32'(bus.o_pwm), 1);
    #1 rst = 1'b1;
    #1;
    expect_outs("async_rst", 0, 0, 0);
    check("async_rst_pwm", 32'(bus.o_pwm), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0;
    repeat (3) tick();
    expect_outs("post_rst", 0, 0, 0);
    check("post_rst_pwm", 32'(bus.o_pwm), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
